// File: rtl/generic_sram_pkg.sv
// Shared types and helpers for the generic 1rw1r SRAM.
package generic_sram_pkg;

  typedef enum logic {INIT, READY} state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  // Widest word expand_mask can describe; callers truncate to their DATA_WIDTH.
  localparam int MASK_MAX_W = 256;

  function automatic logic [MASK_MAX_W-1:0] expand_mask(input logic [MASK_MAX_W-1:0] wmask,
                                                        input int lane_w);
    logic [MASK_MAX_W-1:0] m;
    m = '0;
    for (int i = 0; i < MASK_MAX_W; i++) m[i] = wmask[i / lane_w];
    return m;
  endfunction

endpackage

// File: rtl/generic_sram_rd_pipe.sv
// Read-data latency pipeline: valid shift register plus data stages that
// only advance behind a valid, so the output holds between strobes.
import generic_sram_pkg::*;

module generic_sram_rd_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [READ_LATENCY-1:0]                 vld_pipe;
  logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] dat_pipe;

  if (READ_LATENCY == 1) begin : g_l1
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_pipe <= '0;
        dat_pipe <= '0;
      end else begin
        vld_pipe[0] <= in_valid;
        if (in_valid) dat_pipe[0] <= in_data;
      end
    end
  end else begin : g_ln
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_pipe <= '0;
        dat_pipe <= '0;
      end else begin
        vld_pipe <= {vld_pipe[READ_LATENCY-2:0], in_valid};
        if (in_valid) dat_pipe[0] <= in_data;
        for (int s = 1; s < READ_LATENCY; s++)
          if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
      end
    end
  end

  assign out_valid = vld_pipe[READ_LATENCY-1];
  assign out_data  = dat_pipe[READ_LATENCY-1];

endmodule

// File: rtl/generic_sram_1rw1r.sv
// Parametrised 1rw1r SRAM: masked writes on port 0, reads on both ports,
// configurable read latency, collision policy and post-reset zero sweep.
import generic_sram_pkg::*;

module generic_sram_1rw1r #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_WMASKS   = 4,
  parameter int ADDR_WIDTH   = 9,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_FIRST  = 1,
  parameter int INIT_ZERO    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  init_done,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dout0_valid,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_valid,
  output logic                  collision,
  output logic                  req_dropped
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam int LANE_W    = DATA_WIDTH / NUM_WMASKS;

  if (READ_LATENCY < RD_LAT_MIN || READ_LATENCY > RD_LAT_MAX) begin : g_bad_lat
    $error("generic_sram_1rw1r: READ_LATENCY must be 1 or 2");
  end

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  ready, sweep, wr0, rd0, rd1, coll;
  logic [DATA_WIDTH-1:0] wbits, old0, merged, rdata1;

  logic [1:0]                 rd_vld, out_vld;
  logic [1:0][DATA_WIDTH-1:0] rd_dat, out_dat;

  assign ready     = (state_q == READY);
  assign init_done = ready;
  // Hold the array untouched while reset is asserted; the sweep starts on release.
  assign sweep     = (state_q == INIT) && (INIT_ZERO != 0) && rst_n;

  assign wbits  = DATA_WIDTH'(expand_mask(MASK_MAX_W'(wmask0), LANE_W));
  assign old0   = mem[addr0];
  assign merged = (old0 & ~wbits) | (din0 & wbits);

  assign wr0    = ready && !csb0 && !web0;
  assign rd0    = ready && !csb0 && web0;
  assign rd1    = ready && !csb1;
  assign coll   = wr0 && rd1 && (addr0 == addr1);
  assign rdata1 = (coll && WRITE_FIRST != 0) ? merged : mem[addr1];

  always_comb begin
    state_d = state_q;
    if (state_q == INIT && (INIT_ZERO == 0 || cnt == '1)) state_d = READY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      cnt         <= '0;
      collision   <= 1'b0;
      req_dropped <= 1'b0;
    end else begin
      state_q     <= state_d;
      if (state_q == INIT) cnt <= cnt + 1'b1;
      collision   <= coll;
      req_dropped <= !ready && (!csb0 || !csb1);
    end
  end

  always_ff @(posedge clk) begin
    if (sweep)    mem[cnt]   <= '0;
    else if (wr0) mem[addr0] <= merged;
  end

  assign rd_vld = {rd1, rd0};
  assign rd_dat = {rdata1, old0};

  for (genvar p = 0; p < 2; p++) begin : g_port
    generic_sram_rd_pipe #(
      .DATA_WIDTH  (DATA_WIDTH),
      .READ_LATENCY(READ_LATENCY)
    ) u_pipe (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (rd_vld[p]),
      .in_data  (rd_dat[p]),
      .out_valid(out_vld[p]),
      .out_data (out_dat[p])
    );
  end

  assign dout0_valid = out_vld[0];
  assign dout0       = out_dat[0];
  assign dout1_valid = out_vld[1];
  assign dout1       = out_dat[1];

endmodule

// File: tb/tb_generic_sram_1rw1r.sv
// Directed bench: two instances (latency 1 write-first, latency 2 read-first)
// driven by shared inputs and checked against hand-computed vectors.
module tb_generic_sram_1rw1r;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        csb0 = 1'b1, web0 = 1'b1, csb1 = 1'b1;
  logic [3:0]  wmask0 = '0;
  logic [8:0]  addr0 = '0, addr1 = '0;
  logic [31:0] din0 = '0;

  logic        a_init_done, a_v0, a_v1, a_col, a_drop;
  logic [31:0] a_d0, a_d1;
  logic        b_init_done, b_v0, b_v1, b_col, b_drop;
  logic [31:0] b_d0, b_d1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  generic_sram_1rw1r #(.DATA_WIDTH(32), .NUM_WMASKS(4), .ADDR_WIDTH(9),
                       .READ_LATENCY(1), .WRITE_FIRST(1), .INIT_ZERO(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .init_done(a_init_done),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .dout0(a_d0), .dout0_valid(a_v0),
    .csb1(csb1), .addr1(addr1), .dout1(a_d1), .dout1_valid(a_v1),
    .collision(a_col), .req_dropped(a_drop));

  generic_sram_1rw1r #(.DATA_WIDTH(32), .NUM_WMASKS(4), .ADDR_WIDTH(9),
                       .READ_LATENCY(2), .WRITE_FIRST(0), .INIT_ZERO(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .init_done(b_init_done),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .dout0(b_d0), .dout0_valid(b_v0),
    .csb1(csb1), .addr1(addr1), .dout1(b_d1), .dout1_valid(b_v1),
    .collision(b_col), .req_dropped(b_drop));

  typedef struct {
    string       name;
    logic        csb0, web0;
    logic [3:0]  wmask0;
    logic [8:0]  addr0;
    logic [31:0] din0;
    logic        csb1;
    logic [8:0]  addr1;
    logic        v0;
    logic [31:0] d0;
    logic        v1;
    logic [31:0] d1a, d1b;
    logic        col;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic c0, logic w0, logic [3:0] m, logic [8:0] a0,
                              logic [31:0] d, logic c1, logic [8:0] a1, logic v0,
                              logic [31:0] e0, logic v1, logic [31:0] e1a, logic [31:0] e1b,
                              logic col);
    vec_t v;
    v.name = n; v.csb0 = c0; v.web0 = w0; v.wmask0 = m; v.addr0 = a0; v.din0 = d;
    v.csb1 = c1; v.addr1 = a1; v.v0 = v0; v.d0 = e0; v.v1 = v1; v.d1a = e1a; v.d1b = e1b;
    v.col = col;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%b required=%b", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1; wmask0 = '0;
  endtask

  task automatic wait_init(input string nm);
    int cyc;
    cyc = 0;
    while (cyc < 600) begin
      step();
      cyc++;
      if (cyc == 1) begin
        chkb({nm, "_drop_c1"}, a_drop, 1'b1);
        chkb({nm, "_early_v0"}, a_v0, 1'b0);
        csb0 = 1'b1; csb1 = 1'b0; addr1 = 9'd0;
      end else if (cyc == 2) begin
        chkb({nm, "_drop_c2"}, a_drop, 1'b1);
        chkb({nm, "_early_v1"}, a_v1, 1'b0);
        idle();
      end else if (cyc == 3) begin
        chkb({nm, "_drop_c3"}, a_drop, 1'b0);
      end
      if (a_init_done) break;
    end
    chk({nm, "_init_cycles"}, 32'(cyc), 32'd512);
    chkb({nm, "_b_init_done"}, b_init_done, 1'b1);
  endtask

  vec_t prev;

  initial begin
    vecs.push_back(mk("wr3_masked", 0,0,4'b0101,9'd3,32'hAABBCCDD, 1,9'd0, 0,32'h0,        0,32'h0,        32'h0,        0));
    vecs.push_back(mk("rd3_p0",     0,1,4'b0000,9'd3,32'h0,        1,9'd0, 1,32'h00BB00DD, 0,32'h0,        32'h0,        0));
    vecs.push_back(mk("wr7",        0,0,4'b1111,9'd7,32'h11111111, 1,9'd0, 0,32'h00BB00DD, 0,32'h0,        32'h0,        0));
    vecs.push_back(mk("wr0",        0,0,4'b1111,9'd0,32'h10,       1,9'd0, 0,32'h00BB00DD, 0,32'h0,        32'h0,        0));
    vecs.push_back(mk("wr1",        0,0,4'b1111,9'd1,32'h11,       1,9'd0, 0,32'h00BB00DD, 0,32'h0,        32'h0,        0));
    vecs.push_back(mk("wr2",        0,0,4'b1111,9'd2,32'h12,       1,9'd0, 0,32'h00BB00DD, 0,32'h0,        32'h0,        0));
    vecs.push_back(mk("collide7",   0,0,4'b1111,9'd7,32'h22222222, 0,9'd7, 0,32'h00BB00DD, 1,32'h22222222, 32'h11111111, 1));
    vecs.push_back(mk("rd1_a0",     1,1,4'b0000,9'd0,32'h0,        0,9'd0, 0,32'h00BB00DD, 1,32'h10,       32'h10,       0));
    vecs.push_back(mk("rd1_a1",     1,1,4'b0000,9'd0,32'h0,        0,9'd1, 0,32'h00BB00DD, 1,32'h11,       32'h11,       0));
    vecs.push_back(mk("rd1_a2",     1,1,4'b0000,9'd0,32'h0,        0,9'd2, 0,32'h00BB00DD, 1,32'h12,       32'h12,       0));
    vecs.push_back(mk("rd7_p0",     0,1,4'b0000,9'd7,32'h0,        1,9'd0, 1,32'h22222222, 0,32'h12,       32'h12,       0));
    vecs.push_back(mk("nomask_col", 0,0,4'b0000,9'd3,32'hFFFFFFFF, 0,9'd3, 0,32'h22222222, 1,32'h00BB00DD, 32'h00BB00DD, 1));
    vecs.push_back(mk("rd3_rd2",    0,1,4'b0000,9'd3,32'h0,        0,9'd2, 1,32'h00BB00DD, 1,32'h12,       32'h12,       0));
    vecs.push_back(mk("idle",       1,1,4'b0000,9'd0,32'h0,        1,9'd0, 0,32'h00BB00DD, 0,32'h12,       32'h12,       0));

    // Reset state
    idle();
    step(); step();
    chkb("rst_init_done", a_init_done, 1'b0);
    chk ("rst_dout0", a_d0, 32'h0);
    chk ("rst_dout1", a_d1, 32'h0);
    chkb("rst_v0", a_v0, 1'b0);
    chkb("rst_v1", a_v1, 1'b0);
    chkb("rst_col", a_col, 1'b0);
    chkb("rst_drop", a_drop, 1'b0);
    chkb("rst_b_v1", b_v1, 1'b0);

    // First init, with early requests during the sweep
    @(negedge clk) rst_n = 1'b1;
    csb0 = 1'b0; web0 = 1'b1; addr0 = 9'd0;
    wait_init("init1");

    // Plant a non-zero word, then reset and expect the sweep to clear it
    csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF; addr0 = 9'd5; din0 = 32'hDEADBEEF;
    step();
    idle();
    step();
    @(negedge clk) rst_n = 1'b0;
    step(); step();
    @(negedge clk) rst_n = 1'b1;
    csb0 = 1'b0; web0 = 1'b1; addr0 = 9'd0;
    wait_init("init2");

    csb1 = 1'b0; addr1 = 9'd5; csb0 = 1'b0; web0 = 1'b1; addr0 = 9'd0;
    step();
    idle();
    chkb("sweep_a_v1", a_v1, 1'b1);
    chk ("sweep_a_d1", a_d1, 32'h0);
    chkb("sweep_a_v0", a_v0, 1'b1);
    chkb("sweep_b_v1_early", b_v1, 1'b0);
    step();
    chkb("sweep_b_v1", b_v1, 1'b1);
    chk ("sweep_b_d1", b_d1, 32'h0);
    chkb("sweep_a_v1_off", a_v1, 1'b0);

    // Table: dut_a checked directly, dut_b one cycle later
    prev = mk("pre", 1,1,4'b0,9'd0,32'h0, 1,9'd0, 0,32'h0, 0,32'h0, 32'h0, 0);
    foreach (vecs[k]) begin
      csb0 = vecs[k].csb0; web0 = vecs[k].web0; wmask0 = vecs[k].wmask0;
      addr0 = vecs[k].addr0; din0 = vecs[k].din0;
      csb1 = vecs[k].csb1; addr1 = vecs[k].addr1;
      step();
      chkb({vecs[k].name, "_a_v0"}, a_v0, vecs[k].v0);
      chk ({vecs[k].name, "_a_d0"}, a_d0, vecs[k].d0);
      chkb({vecs[k].name, "_a_v1"}, a_v1, vecs[k].v1);
      chk ({vecs[k].name, "_a_d1"}, a_d1, vecs[k].d1a);
      chkb({vecs[k].name, "_a_col"}, a_col, vecs[k].col);
      chkb({vecs[k].name, "_a_drop"}, a_drop, 1'b0);
      chkb({vecs[k].name, "_b_col"}, b_col, vecs[k].col);
      chkb({prev.name, "_b_v0"}, b_v0, prev.v0);
      chk ({prev.name, "_b_d0"}, b_d0, prev.d0);
      chkb({prev.name, "_b_v1"}, b_v1, prev.v1);
      chk ({prev.name, "_b_d1"}, b_d1, prev.d1b);
      prev = vecs[k];
    end
    idle();
    step();
    chkb("tail_b_v1", b_v1, 1'b0);
    chk ("tail_b_d1", b_d1, 32'h12);

    // Reset while a latency-2 read is in flight on dut_b
    csb1 = 1'b0; addr1 = 9'd7;
    step();
    chkb("flight_a_v1", a_v1, 1'b1);
    chk ("flight_a_d1", a_d1, 32'h22222222);
    chkb("flight_b_v1_pre", b_v1, 1'b0);
    idle();
    rst_n = 1'b0;
    #1;
    chkb("midrst_b_v1", b_v1, 1'b0);
    chk ("midrst_b_d1", b_d1, 32'h0);
    chk ("midrst_a_d1", a_d1, 32'h0);
    chkb("midrst_b_init", b_init_done, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      chkb("midrst_b_v1_hold", b_v1, 1'b0);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chkb("post_b_v1", b_v1, 1'b0);
      chk ("post_b_d1", b_d1, 32'h0);
      chkb("post_b_init", b_init_done, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
